// File: rtl/multi_32bit.sv
// Four-stage pipelined 32x32 unsigned multiplier, low 32 product bits.
// Each stage adds the partial products for one byte of B.
module multi_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] F
);

  logic [31:0] a1, a2, a3;
  logic [23:0] b1;
  logic [15:0] b2;
  logic [7:0]  b3;
  logic [31:0] acc1, acc2, acc3;
  logic [31:0] pp1, pp2, pp3, pp4;

  // Sum of a shifted by each set bit of one B byte, offset by the lane position.
  function automatic logic [31:0] lane_sum(input logic [31:0] a, input logic [7:0] b,
                                           input int unsigned sh);
    logic [31:0] s;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) s = s + (a << (i + sh));
    end
    return s;
  endfunction

  always_comb begin
    pp1 = lane_sum(A,  B[7:0],  0);
    pp2 = lane_sum(a1, b1[7:0], 8);
    pp3 = lane_sum(a2, b2[7:0], 16);
    pp4 = lane_sum(a3, b3,      24);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1   <= '0;
      a2   <= '0;
      a3   <= '0;
      b1   <= '0;
      b2   <= '0;
      b3   <= '0;
      acc1 <= '0;
      acc2 <= '0;
      acc3 <= '0;
      F    <= '0;
    end else begin
      a1   <= A;
      b1   <= B[31:8];
      acc1 <= pp1;
      a2   <= a1;
      b2   <= b1[23:8];
      acc2 <= acc1 + pp2;
      a3   <= a2;
      b3   <= b2[15:8];
      acc3 <= acc2 + pp3;
      F    <= acc3 + pp4;
    end
  end

endmodule

// File: tb/tb_multi_32bit.sv
// Scoreboard bench for multi_32bit: driver pushes (A*B) mod 2^32, monitor pops per edge.
module tb_multi_32bit;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] F;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [31:0] exp_q[$];

  multi_32bit dut (
    .clk(clk),
    .rst(rst),
    .A  (A),
    .B  (B),
    .F  (F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Operands are applied on the falling edge; the expected product is queued at once.
  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    @(negedge clk);
    A = a;
    B = b;
    p = a * b;
    exp_q.push_back(p);
  endtask

  // Release reset on a falling edge; the three flushed stages ahead of F read as zero.
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (3) exp_q.push_back(32'h0);
  endtask

  // Monitor: one result per rising edge while out of reset.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("reset_hold", F, 32'h0);
      end else if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL underflow: got 0x%08h with empty scoreboard at %0t", F, $time);
      end else begin
        e = exp_q.pop_front();
        check("result", F, e);
      end
    end
  end

  logic [31:0] dir_a [10] = '{32'hC000, 32'hAA00, 32'hA01, 32'h30, 32'h20, 32'h3,
                              32'h9000, 32'h10000, 32'hFFFFFFFF, 32'h12345678};
  logic [31:0] dir_b [10] = '{32'h1000, 32'h100, 32'h20, 32'h9, 32'h10, 32'h1,
                              32'h8000, 32'h10000, 32'hFFFFFFFF, 32'h9ABCDEF0};
  logic [31:0] dir_f [10] = '{32'h0C000000, 32'h00AA0000, 32'h00014020, 32'h1B0, 32'h200,
                              32'h3, 32'h48000000, 32'h0, 32'h00000001, 32'h242D2080};

  initial begin
    logic [31:0] ra, rb, p;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    A = '0;
    B = '0;
    #3;
    check("reset_state", F, 32'h0);
    repeat (2) @(negedge clk);
    release_rst();
    A = 32'h0;
    B = 32'h1;
    p = A * B;
    exp_q.push_back(p);
    drive(32'h10, 32'h1);
    drive(32'hF0, 32'h40);

    // Hand-computed byte-lane and truncation vectors, checked against the model too.
    for (int i = 0; i < 10; i++) begin
      p = dir_a[i] * dir_b[i];
      check("model_vector", p, dir_f[i]);
      drive(dir_a[i], dir_b[i]);
    end

    for (int i = 0; i < 20; i++) drive(32'hDEADBEEF, 32'h01020304);

    for (int i = 0; i < 1000; i++) drive($urandom, $urandom);

    // Mid-stream reset with nonzero products in flight.
    for (int i = 0; i < 4; i++) drive(32'h11111111 + i, 32'h3);
    @(negedge clk);
    #1;
    check("in_flight_nonzero", {31'h0, (F != 32'h0)}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    check("async_clear", F, 32'h0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A = $urandom;
      B = $urandom;
    end
    release_rst();
    ra = 32'h0000_1234;
    rb = 32'h0000_0100;
    A = ra;
    B = rb;
    p = ra * rb;
    exp_q.push_back(p);
    for (int i = 0; i < 50; i++) drive($urandom, $urandom);

    for (int i = 0; i < 4; i++) drive(32'h0, 32'h0);
    @(negedge clk);
    check("drain_depth", exp_q.size(), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
